// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through data cache with one word per line and one outstanding DRAM request.
// Optional feature macro: DCACHE_WRITE_ALLOCATE_EN (allocate the line on a write miss when the DRAM acks).
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

module dcache_wt #(
    parameter int ADDR_W  = `DRAM_ADDRESS_SIZE,
    parameter int DATA_W  = `DRAM_WORD_SIZE,
    parameter int INDEX_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   dcache_address,
    input  logic                dcache_dataRequest,
    input  logic                dcache_rw,
    input  logic [DATA_W-1:0]   dcache_writeData,
    input  logic [DATA_W/8-1:0] dcache_byte_en,
    output logic [DATA_W-1:0]   dcache_readData,
    output logic                dcache_data_ready,
    output logic                transfer_in_progress,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_en,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);
    // state   | meaning
    // IDLE    | accept requests, answer read hits combinationally
    // RD_MISS | line fetch outstanding at DRAM
    // WR_THRU | store outstanding at DRAM
    // RESP    | one-cycle completion pulse to the CPU
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_MISS = 2'd1;
    localparam logic [1:0] S_WR_THRU = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int BE_W  = DATA_W / 8;

    logic [1:0]        state, state_nxt;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES];
    logic [DATA_W-1:0] rdata_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               rd_hit;
    logic               fill;
    logic               wr_start;
    logic               unused_offset;

    assign idx           = dcache_address[INDEX_W+1:2];
    assign tag           = dcache_address[ADDR_W-1:INDEX_W+2];
    assign hit           = valid[idx] && (tag_arr[idx] == tag);
    assign rd_hit        = (state == S_IDLE) && dcache_dataRequest && !dcache_rw && hit;
    assign fill          = (state == S_RD_MISS) && mem_ack;
    assign wr_start      = (state == S_IDLE) && dcache_dataRequest && dcache_rw;
    assign unused_offset = &{1'b0, dcache_address[1:0]};

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] base,
                                                      input logic [DATA_W-1:0] upd,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = base;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = upd[b*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (wr_start) state_nxt = S_WR_THRU;
                else if (dcache_dataRequest && !hit) state_nxt = S_RD_MISS;
            end
            S_RD_MISS: if (mem_ack) state_nxt = S_RESP;
            S_WR_THRU: if (mem_ack) state_nxt = S_RESP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            valid   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (fill) begin
                valid[idx] <= 1'b1;
                rdata_q    <= mem_rdata;
            end
`ifdef DCACHE_WRITE_ALLOCATE_EN
            if ((state == S_WR_THRU) && mem_ack && !hit) valid[idx] <= 1'b1;
`endif
        end
    end

    // Tag/data arrays need no reset: nothing reads them unless the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= mem_rdata;
        end else if (wr_start && hit) begin
            data_arr[idx] <= merge_bytes(data_arr[idx], dcache_writeData, dcache_byte_en);
        end
`ifdef DCACHE_WRITE_ALLOCATE_EN
        else if ((state == S_WR_THRU) && mem_ack && !hit) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= merge_bytes(mem_rdata, dcache_writeData, dcache_byte_en);
        end
`endif
    end

    assign transfer_in_progress = (state == S_RD_MISS) || (state == S_WR_THRU);
    assign mem_req              = transfer_in_progress;
    assign mem_we               = (state == S_WR_THRU);
    assign mem_addr             = mem_req ? {dcache_address[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata            = mem_we ? dcache_writeData : '0;
    assign mem_byte_en          = mem_we ? dcache_byte_en : '0;
    assign dcache_data_ready    = rd_hit || (state == S_RESP);

    always_comb begin
        dcache_readData = '0;
        if (rd_hit) dcache_readData = data_arr[idx];
        else if ((state == S_RESP) && !dcache_rw) dcache_readData = rdata_q;
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt: a behavioural cache/DRAM model predicts every output on every cycle.
module tb_dcache_wt;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 6;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] dcache_address;
    logic          dcache_dataRequest;
    logic          dcache_rw;
    logic [DW-1:0] dcache_writeData;
    logic [3:0]    dcache_byte_en;
    logic [DW-1:0] dcache_readData;
    logic          dcache_data_ready;
    logic          transfer_in_progress;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_byte_en;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    always #5 clk = ~clk;

    dcache_wt #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .dcache_address(dcache_address), .dcache_dataRequest(dcache_dataRequest),
        .dcache_rw(dcache_rw), .dcache_writeData(dcache_writeData),
        .dcache_byte_en(dcache_byte_en), .dcache_readData(dcache_readData),
        .dcache_data_ready(dcache_data_ready), .transfer_in_progress(transfer_in_progress),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    logic          e_ready, e_tip, e_req, e_we;
    logic [31:0]   e_addr, e_wdata, e_rdata;
    logic [3:0]    e_be;
    bit            chk_en = 1'b0;

    // Behavioural model: flat DRAM image of 256 words plus a per-index line record
    logic [31:0] dram [256];
    bit          cvalid [64];
    int          ctag [64];
    logic [31:0] cdata [64];

    logic [31:0] last_rdata = '0;
    int req_cnt = 0;
    int tip_cnt = 0;
    int rdy_cnt = 0;

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (nw & mask) | (old & ~mask);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ready", 32'(dcache_data_ready), 32'(e_ready));
            cmp("readData", dcache_readData, e_rdata);
            cmp("tip", 32'(transfer_in_progress), 32'(e_tip));
            cmp("mem_req", 32'(mem_req), 32'(e_req));
            cmp("mem_we", 32'(mem_we), 32'(e_we));
            cmp("mem_addr", mem_addr, e_addr);
            cmp("mem_wdata", mem_wdata, e_wdata);
            cmp("mem_byte_en", 32'(mem_byte_en), 32'(e_be));
            if (dcache_data_ready) begin
                last_rdata = dcache_readData;
                rdy_cnt++;
            end
            if (mem_req) req_cnt++;
            if (transfer_in_progress) tip_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_zero();
        e_ready = 0; e_tip = 0; e_req = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) cvalid[i] = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            dcache_dataRequest = 0;
            dcache_rw = 1'($urandom);
            dcache_address = 32'($urandom_range(0, 1023));
            mem_ack = 1'($urandom);
            mem_rdata = $urandom;
            exp_zero();
            step();
        end
        mem_ack = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        dcache_dataRequest = 0;
        mem_ack = 0;
        clear_model();
        exp_zero();
        step();
        step();
        reset = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int n);
        int ix, tg, w;
        ix = int'(a[7:2]); tg = int'(a[9:8]); w = int'(a[9:2]);
        dcache_address = a; dcache_dataRequest = 1; dcache_rw = 0;
        dcache_writeData = $urandom; dcache_byte_en = 4'($urandom);
        mem_ack = 0; mem_rdata = $urandom;
        exp_zero();
        if (cvalid[ix] && ctag[ix] == tg) begin
            e_ready = 1; e_rdata = cdata[ix];
            step();
        end else begin
            step();
            for (int c = 1; c <= n; c++) begin
                exp_zero();
                e_tip = 1; e_req = 1; e_addr = {a[31:2], 2'b00};
                mem_ack = (c == n);
                mem_rdata = (c == n) ? dram[w] : $urandom;
                step();
            end
            mem_ack = 0; mem_rdata = $urandom;
            exp_zero();
            e_ready = 1; e_rdata = dram[w];
            cvalid[ix] = 1; ctag[ix] = tg; cdata[ix] = dram[w];
            step();
        end
        dcache_dataRequest = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input int n);
        int ix, tg, w;
        bit h;
        logic [31:0] merged;
        ix = int'(a[7:2]); tg = int'(a[9:8]); w = int'(a[9:2]);
        h = cvalid[ix] && ctag[ix] == tg;
        merged = mrg(dram[w], wd, be);
        dcache_address = a; dcache_dataRequest = 1; dcache_rw = 1;
        dcache_writeData = wd; dcache_byte_en = be;
        mem_ack = 0; mem_rdata = $urandom;
        exp_zero();
        step();
        for (int c = 1; c <= n; c++) begin
            exp_zero();
            e_tip = 1; e_req = 1; e_we = 1; e_addr = {a[31:2], 2'b00}; e_wdata = wd; e_be = be;
            mem_ack = (c == n);
            mem_rdata = (c == n) ? merged : $urandom;
            step();
        end
        mem_ack = 0; mem_rdata = $urandom;
        exp_zero();
        e_ready = 1;
        dram[w] = merged;
        if (h) begin
            cdata[ix] = merged;
        end else if (ALLOC) begin
            cvalid[ix] = 1; ctag[ix] = tg; cdata[ix] = merged;
        end
        step();
        dcache_dataRequest = 0;
    endtask

    initial begin
        reset = 1;
        dcache_address = '0; dcache_dataRequest = 0; dcache_rw = 0;
        dcache_writeData = '0; dcache_byte_en = '0;
        mem_rdata = '0; mem_ack = 0;
        for (int i = 0; i < 256; i++) dram[i] = $urandom;
        clear_model();
        exp_zero();
        step();
        chk_en = 1;
        step();
        reset = 0;
        idle(1);

        // Directed: cold miss then hit on 0x040
        dram[8'h10] = 32'hDEADBEEF;
        req_cnt = 0;
        do_read(32'h040, 3);
        cmp("miss_data", last_rdata, 32'hDEADBEEF);
        cmp("miss_req_cycles", 32'(req_cnt), 32'd3);
        req_cnt = 0;
        do_read(32'h040, 1);
        cmp("hit_data", last_rdata, 32'hDEADBEEF);
        cmp("hit_req_cycles", 32'(req_cnt), 32'd0);

        // Partial write hit, then read back merged word
        do_write(32'h040, 32'h11223344, 4'b0011, 2);
        do_read(32'h041, 1);
        cmp("merge_data", last_rdata, 32'hDEAD3344);

        // Conflict eviction at index 16
        do_read(32'h140, 2);
        req_cnt = 0;
        do_read(32'h040, 2);
        cmp("evict_req_cycles", 32'(req_cnt), 32'd2);
        cmp("evict_data", last_rdata, 32'hDEAD3344);

        // Write miss, then read: hit only with write-allocate
        do_write(32'h080, 32'hCAFEF00D, 4'hF, 2);
        req_cnt = 0;
        do_read(32'h080, 2);
        cmp("wmiss_req_cycles", 32'(req_cnt), ALLOC ? 32'd0 : 32'd2);
        cmp("wmiss_data", last_rdata, 32'hCAFEF00D);

        // Reset in the middle of a read miss; the late ack must be ignored
        dcache_address = 32'h0C4; dcache_dataRequest = 1; dcache_rw = 0; mem_ack = 0;
        exp_zero();
        step();
        exp_zero();
        e_tip = 1; e_req = 1; e_addr = 32'h0C4;
        step();
        rdy_cnt = 0;
        reset = 1;
        clear_model();
        exp_zero();
        step();
        reset = 0; dcache_dataRequest = 0; mem_ack = 1; mem_rdata = $urandom;
        step();
        mem_ack = 0;
        idle(1);
        cmp("rst_no_ready", 32'(rdy_cnt), 32'd0);
        req_cnt = 0;
        do_read(32'h0C4, 2);
        cmp("rst_miss_req_cycles", 32'(req_cnt), 32'd2);

        // Fastest miss: ack in the first request cycle
        tip_cnt = 0;
        do_read(32'h3FC, 1);
        cmp("fast_tip_cycles", 32'(tip_cnt), 32'd1);

        // Randomized traffic, back-to-back or with short gaps
        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 59) == 0) apply_reset();
            if ($urandom_range(0, 2) == 0)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(1, 4)));
            else
                do_read(a, int'($urandom_range(1, 4)));
            idle(int'($urandom_range(0, 2)));
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through data cache that is the responder on the datapath's `dcache_*` port. It is placed between the pipelined datapath and the DRAM controller. Read hits return data in the same cycle. Misses and all writes go to DRAM through a single-outstanding request/acknowledge port, and the cache holds the pipeline while they are in flight.

## Interface
Parameters:
- `ADDR_W`, default `` `DRAM_ADDRESS_SIZE ``: byte-address width.
- `DATA_W`, default `` `DRAM_WORD_SIZE `` (32): word width. One word per line.
- `INDEX_W`, default 6: log2 of line count (64 lines).

Ports:
- `clk`  in  1  clock. Rising edge only.
- `reset`  in  1  asynchronous, active-high reset.
- `dcache_address`  in  ADDR_W  CPU byte address.
- `dcache_dataRequest`  in  1  CPU request valid.
- `dcache_rw`  in  1  1 = write, 0 = read.
- `dcache_writeData`  in  DATA_W  store data.
- `dcache_byte_en`  in  DATA_W/8  store byte lanes.
- `dcache_readData`  out  DATA_W  load data.
- `dcache_data_ready`  out  1  request completes this cycle.
- `transfer_in_progress`  out  1  DRAM transaction active; the pipeline stalls while it is high.
- `mem_req`  out  1  DRAM request valid.
- `mem_we`  out  1  DRAM write.
- `mem_addr`  out  ADDR_W  word-aligned DRAM address.
- `mem_wdata`  out  DATA_W  DRAM write data.
- `mem_byte_en`  out  DATA_W/8  DRAM byte lanes.
- `mem_rdata`  in  DATA_W  DRAM read data.
- `mem_ack`  in  1  one-cycle DRAM completion.

## Operation
- Address split:
  - offset = `[1:0]`, ignored; accesses are word-aligned.
  - index = `[INDEX_W+1:2]`.
  - tag = `[ADDR_W-1:INDEX_W+2]`.
- Storage per line: valid bit, tag, data word. Arrays are read asynchronously and written on `clk`.
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE:
  - Read hit (valid, tag match, `dcache_rw`=0): `dcache_data_ready`=1 and `dcache_readData` = line data, combinationally. State stays IDLE.
  - Read miss → RD_MISS.
  - Any write: on a hit, update the cached bytes selected by `dcache_byte_en`; then → WR_THRU.
- RD_MISS:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = `{address[ADDR_W-1:2], 2'b00}`.
  - On `mem_ack`: write data, tag and valid=1 into the line (replacing any other tag), capture `mem_rdata`, → RESP.
- WR_THRU:
  - Drive `mem_req`=1, `mem_we`=1, aligned address, `mem_wdata` = `dcache_writeData`, `mem_byte_en` = `dcache_byte_en`.
  - On `mem_ack` → RESP.
  - Write misses do not allocate (see Configuration).
- RESP:
  - `dcache_data_ready`=1 for exactly one cycle.
  - For reads, `dcache_readData` = captured word.
  - → IDLE.
- `transfer_in_progress` is 1 in RD_MISS and WR_THRU, 0 otherwise.
- Request fields are sampled combinationally. The CPU holds them stable until `dcache_data_ready`. The cache does not re-check the request in RD_MISS or WR_THRU.
- `dcache_readData` is 0 whenever `dcache_data_ready`=0.
- Outputs are `mem_*` held stable while `mem_req`=1 and no `mem_ack` has arrived.
- `mem_ack` in IDLE or RESP is ignored.

## Timing
- Reset (async, immediate):
  - State → IDLE; all valid bits cleared.
  - `dcache_data_ready`, `transfer_in_progress`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `mem_byte_en`, `dcache_readData` = 0.
- Reset during RD_MISS or WR_THRU abandons the transaction. A later `mem_ack` is ignored and no line is written.
- Read hit latency: 0 cycles.
- Read miss latency: N+1 cycles, where N = cycles until `mem_ack`; ready is asserted in the RESP cycle.
- Write latency: N+1 cycles, same rule, hit or miss.
- `mem_ack` may arrive in the first cycle of `mem_req` (N=1), giving a 2-cycle miss.
- A request in the cycle after RESP is accepted normally in IDLE.
- Line fill and write-hit update happen on the `clk` edge that leaves RD_MISS, or that leaves IDLE for a write.
- A read hit to the same index immediately after RESP returns the new data.

## Configuration
- `DCACHE_WRITE_ALLOCATE_EN` defined: on a write miss, when `mem_ack` arrives in WR_THRU, the line is set valid with the new tag.
  - Data bytes with `byte_en`=1 take `dcache_writeData`.
  - Data bytes with `byte_en`=0 take `mem_rdata`; the DRAM returns the merged word on write ack.
- Not defined: write misses leave the cache untouched. `mem_rdata` is ignored on writes.

## Test plan
- Reset, read 0x040 (DRAM word 0xDEADBEEF, ack after 3 cycles) → `mem_req` for 3 cycles, ready with 0xDEADBEEF in cycle 4. Re-read 0x040 → ready and 0xDEADBEEF same cycle, no `mem_req`.
- Write 0x11223344, byte_en 4'b0011, to cached 0x040 → `mem_we`=1, `mem_byte_en`=0011. Next read hit returns 0xDEAD3344.
- Read 0x140 (same index as 0x040, different tag) → miss, fill. Read 0x040 → miss again (eviction).
- Write miss to 0x080 → WR_THRU, ready after ack. Read 0x080 → hit only with `DCACHE_WRITE_ALLOCATE_EN`, miss without it.
- Assert `reset` during RD_MISS, then deliver `mem_ack` → no ready pulse. A later read of that address misses.
- `mem_ack` in the first RD_MISS cycle → ready exactly 2 cycles after the request. `transfer_in_progress` high for 1 cycle.
